seg_scan_decoder: RTL



---
 rtl/seg_scan_decoder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - rebuilds the 32-bit hex value scanned on an 8-digit AN/SEG bus
// Optional feature macro: SEG_DP_CAPTURE_EN (per-digit decimal point capture onto dp_o)
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  AN,
  input  logic [7:0]  SEG,
  output logic [31:0] value_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  dp_o,
  output logic        bad_o,
  output logic        overrun_o
);

  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_t;

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

  state_t      state;
  logic [7:0]  prev_an;
  logic [7:0]  cnt;
  logic [6:0]  seg_q;
  logic [7:0]  seen;
  logic [7:0]  seen_next;
  logic [31:0] staging;

  logic [7:0]  sel;
  logic        an_changed;
  logic        sel_zero;
  logic        sel_onehot;
  logic [2:0]  digit_idx;
  logic        seg_legal;
  logic [3:0]  seg_nib;
  logic        frame_done;
  logic        sample_ok;

`ifdef SEG_DP_CAPTURE_EN
  logic [7:0]  dp_stage;
  logic        seg_dp_q;
`else
  logic        unused_seg_dp;
  assign unused_seg_dp = SEG[7];
  assign dp_o          = 8'h00;
`endif

  // Classify the live anode pattern and detect a change from the previous cycle
  always_comb begin
    sel        = ~AN;
    an_changed = (AN != prev_an);
    sel_zero   = (sel == 8'h00);
    sel_onehot = !sel_zero && ((sel & (sel - 8'd1)) == 8'h00);
  end

  // Digit index of the settled dwell; in SAMPLE prev_an still holds that dwell's pattern
  always_comb begin
    digit_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!prev_an[i]) digit_idx = 3'(i);
    end
  end

  // Active-low gfedcba pattern (as sampled at the end of settling) to hex nibble
  always_comb begin
    seg_legal = 1'b1;
    seg_nib   = 4'h0;
    case (seg_q)
      7'h40:   seg_nib = 4'h0;
      7'h79:   seg_nib = 4'h1;
      7'h24:   seg_nib = 4'h2;
      7'h30:   seg_nib = 4'h3;
      7'h19:   seg_nib = 4'h4;
      7'h12:   seg_nib = 4'h5;
      7'h02:   seg_nib = 4'h6;
      7'h78:   seg_nib = 4'h7;
      7'h00:   seg_nib = 4'h8;
      7'h10:   seg_nib = 4'h9;
      7'h08:   seg_nib = 4'hA;
      7'h03:   seg_nib = 4'hB;
      7'h46:   seg_nib = 4'hC;
      7'h21:   seg_nib = 4'hD;
      7'h06:   seg_nib = 4'hE;
      7'h0E:   seg_nib = 4'hF;
      default: seg_legal = 1'b0;
    endcase
  end

  // Seen mask: a completed frame clears it, and a legal sample landing the same cycle starts the next one
  always_comb begin
    frame_done = (seen == 8'hFF);
    sample_ok  = (state == ST_SAMPLE) && seg_legal;
    seen_next  = frame_done ? 8'h00 : seen;
    if (sample_ok) seen_next[digit_idx] = 1'b1;
  end

  // Scan FSM, staging slots and the frame handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_WAIT;
      prev_an   <= 8'hFF;
      cnt       <= 8'd0;
      seg_q     <= 7'h7F;
      seen      <= 8'h00;
      staging   <= 32'h0;
      value_o   <= 32'h0;
      valid_o   <= 1'b0;
      bad_o     <= 1'b0;
      overrun_o <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_stage  <= 8'h00;
      seg_dp_q  <= 1'b0;
      dp_o      <= 8'h00;
`endif
    end else begin
      prev_an <= AN;
      seg_q   <= SEG[6:0];
      seen    <= seen_next;
      bad_o   <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      seg_dp_q <= ~SEG[7];
`endif

      // Frame delivery: a full frame either lands or is dropped as an overrun
      if (frame_done) begin
        if (!valid_o || ready_i) begin
          value_o <= staging;
          valid_o <= 1'b1;
`ifdef SEG_DP_CAPTURE_EN
          dp_o    <= dp_stage;
`endif
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      // The sample uses SEG as it stood on the last settled cycle, even if AN moves on now
      if (state == ST_SAMPLE) begin
        if (seg_legal) staging[{digit_idx, 2'b00} +: 4] <= seg_nib;
        else           bad_o <= 1'b1;
`ifdef SEG_DP_CAPTURE_EN
        dp_stage[digit_idx] <= seg_dp_q;
`endif
      end

      if (an_changed) begin
        if (sel_onehot) begin
          cnt   <= 8'd1;
          state <= (SETTLE_N == 8'd1) ? ST_SAMPLE : ST_SETTLE;
        end else begin
          cnt   <= 8'd0;
          state <= ST_WAIT;
          if (!sel_zero) bad_o <= 1'b1;
        end
      end else begin
        case (state)
          ST_SETTLE: begin
            cnt <= cnt + 8'd1;
            if (cnt + 8'd1 == SETTLE_N) state <= ST_SAMPLE;
          end
          ST_SAMPLE: state <= ST_HOLD;
          default:   state <= state;
        endcase
      end
    end
  end

endmodule
